// File: rtl/bp_pkg.sv
// Shared types and helpers for the bimodal branch-predictor table controller.
//   ctr_t       : 2-bit saturating counter (bit 1 is the predicted direction)
//   CTR_RESET   : value written to every entry while the table is cleared
//   CTR_MAX     : saturation ceiling for taken updates
//   fsm_e       : controller state (INIT clears the table, RUN serves requests)
//   sat_update  : next counter value for a resolved branch outcome
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_RESET = 2'b00;
  localparam ctr_t CTR_MAX   = 2'b11;

  typedef enum logic {
    INIT,
    RUN
  } fsm_e;

  function automatic ctr_t sat_update(ctr_t c, logic taken);
    ctr_t r;
    if (taken) begin
      r = (c == CTR_MAX) ? c : ctr_t'(c + 2'd1);
    end else begin
      r = (c == CTR_RESET) ? c : ctr_t'(c - 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small FIFO holding resolved-branch updates until the table port is free.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (empties the queue)
//   push_i          : enqueue {push_idx_i, push_taken_i}; ignored when full
//   pop_i           : drop the head entry; ignored when empty
//   head_idx_o/head_taken_o : current head entry (valid when !empty_o)
//   full_o, empty_o, count_o : occupancy status
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int IDX_W   = 6,
  parameter int Q_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [IDX_W-1:0]           push_idx_i,
  input  logic                       push_taken_i,
  input  logic                       pop_i,
  output logic [IDX_W-1:0]           head_idx_o,
  output logic                       head_taken_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Q_DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry layout: {idx, taken}
  logic [IDX_W:0]  mem_q [Q_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(Q_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_idx_o   = mem_q[rd_ptr_q][IDX_W:1];
  assign head_taken_o = mem_q[rd_ptr_q][0];

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (do_pop)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    case ({do_push, do_pop})
      2'b10:   count_d = CNT_W'(count_q + 1'b1);
      2'b01:   count_d = CNT_W'(count_q - 1'b1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_idx_i, push_taken_i};
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// Bimodal branch-predictor table controller.
// Clears a table of 2-bit saturating counters after reset, then shares its single
// access port between fetch-side lookups (priority) and queued commit-side updates.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   lookup_valid/lookup_pc        : prediction request
//   lookup_ready                  : lookup accepted this cycle
//   pred_valid/pred_taken         : prediction, one cycle after an accepted lookup
//   upd_valid/upd_pc/upd_taken    : resolved-branch update request
//   upd_ready                     : update enqueued this cycle
//   q_count                       : number of queued updates
module bp_table_ctrl
  import bp_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int IDX_W   = 6,
  parameter int Q_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lookup_valid,
  input  logic [PC_W-1:0]          lookup_pc,
  output logic                     lookup_ready,
  output logic                     pred_valid,
  output logic                     pred_taken,
  input  logic                     upd_valid,
  input  logic [PC_W-1:0]          upd_pc,
  input  logic                     upd_taken,
  output logic                     upd_ready,
  output logic [$clog2(Q_DEPTH):0] q_count
);

  localparam int ENTRIES = 2 ** IDX_W;

  fsm_e             state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;

  ctr_t             tbl_q [ENTRIES];
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  ctr_t             tbl_wdata;

  logic [IDX_W-1:0] lookup_idx, upd_idx, head_idx;
  logic             head_taken;
  logic             q_full, q_empty;
  logic             lookup_acc, upd_acc, drain;

  // Word-aligned PCs: the two low bits and the bits above the index never matter.
  assign lookup_idx = lookup_pc[IDX_W+1:2];
  assign upd_idx    = upd_pc[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                            upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

  bp_upd_fifo #(
    .IDX_W   (IDX_W),
    .Q_DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (upd_acc),
    .push_idx_i   (upd_idx),
    .push_taken_i (upd_taken),
    .pop_i        (drain),
    .head_idx_o   (head_idx),
    .head_taken_o (head_taken),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .count_o      (q_count)
  );

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    lookup_ready = 1'b0;
    upd_ready    = 1'b0;
    lookup_acc   = 1'b0;
    upd_acc      = 1'b0;
    drain        = 1'b0;
    tbl_we       = 1'b0;
    tbl_waddr    = init_idx_q;
    tbl_wdata    = CTR_RESET;
    pred_valid_d = 1'b0;
    pred_taken_d = pred_taken_q;

    case (state_q)
      INIT: begin
        tbl_we     = 1'b1;
        init_idx_d = IDX_W'(init_idx_q + 1'b1);
        if (init_idx_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
      end
      RUN: begin
        // Readies depend only on registered state, never on the request inputs.
        lookup_ready = !q_full;
        upd_ready    = !q_full;
        lookup_acc   = lookup_valid && lookup_ready;
        upd_acc      = upd_valid && upd_ready;
        // A full queue blocks lookups, so the drain always wins that cycle.
        drain        = !q_empty && (!lookup_acc || q_full);
        if (lookup_acc) begin
          pred_valid_d = 1'b1;
          pred_taken_d = tbl_q[lookup_idx][1];
        end
        if (drain) begin
          tbl_we    = 1'b1;
          tbl_waddr = head_idx;
          tbl_wdata = sat_update(tbl_q[head_idx], head_taken);
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      init_idx_q   <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
    end
  end

  // Counter array has no reset of its own; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl_q[tbl_waddr] <= tbl_wdata;
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;

endmodule

// File: tb/tb_bp_table_ctrl.sv
module tb_bp_table_ctrl;

  localparam int PC_W    = 32;
  localparam int IDX_W   = 6;
  localparam int Q_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        lookup_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_ready;
  logic [2:0]  q_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_table_ctrl #(
    .PC_W    (PC_W),
    .IDX_W   (IDX_W),
    .Q_DEPTH (Q_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .lookup_ready (lookup_ready),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_ready    (upd_ready),
    .q_count      (q_count)
  );

  typedef struct {
    logic        is_lookup;
    logic [31:0] pc;
    logic        taken;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the controller is idle: RUN state and queue empty.
  task automatic wait_idle(input string name);
    int n = 0;
    while (!(lookup_ready && q_count == 3'd0) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check({name, "_idle_timeout"}, 32'(n), 32'd0);
  endtask

  // Counts cycles from reset release until lookup_ready rises.
  task automatic count_init(input string name);
    int n = 0;
    while (!lookup_ready && n < 200) begin
      if (upd_ready) check({name, "_upd_ready_in_init"}, 32'(upd_ready), 32'd0);
      step();
      n++;
    end
    check({name, "_init_cycles"}, 32'(n), 32'd64);
    check({name, "_upd_ready_after"}, 32'(upd_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    wait_idle($sformatf("v%0d", k));
    if (v.is_lookup) begin
      lookup_valid = 1'b1;
      lookup_pc    = v.pc;
      step();
      lookup_valid = 1'b0;
      check($sformatf("v%0d_pred_valid pc=%0h", k, v.pc), 32'(pred_valid), 32'd1);
      check($sformatf("v%0d_pred_taken pc=%0h", k, v.pc), 32'(pred_taken), 32'(v.exp_taken));
      step();
      check($sformatf("v%0d_pred_valid_drop", k), 32'(pred_valid), 32'd0);
    end else begin
      upd_valid = 1'b1;
      upd_pc    = v.pc;
      upd_taken = v.taken;
      step();
      upd_valid = 1'b0;
      $display("upd  v%0d pc=%0h taken=%0b", k, v.pc, v.taken);
    end
  endtask

  function automatic vec_t mk(input logic l, input logic [31:0] pc, input logic t, input logic e);
    vec_t v;
    v.is_lookup = l;
    v.pc        = pc;
    v.taken     = t;
    v.exp_taken = e;
    return v;
  endfunction

  initial begin
    // Index 0: first lookup after INIT.
    vecs.push_back(mk(1, 32'h0,   0, 0));
    // After training idx 1 to counter 2.
    vecs.push_back(mk(1, 32'h104, 0, 1));
    vecs.push_back(mk(1, 32'h108, 0, 0));
    // Saturation on 0x10 (idx 4): 5 taken -> 3, 1 not-taken -> 2.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 32'h10, 1, 0));
    vecs.push_back(mk(0, 32'h10, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 1));
    vecs.push_back(mk(0, 32'h10, 0, 0));
    vecs.push_back(mk(0, 32'h10, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0));
    vecs.push_back(mk(0, 32'h10, 0, 0));
    vecs.push_back(mk(0, 32'h10, 1, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0));
    // Alias: 0x100 and 0x200 both map to idx 0.
    vecs.push_back(mk(0, 32'h100, 1, 0));
    vecs.push_back(mk(0, 32'h100, 1, 0));
    vecs.push_back(mk(1, 32'h200, 0, 1));
    vecs.push_back(mk(1, 32'h0,   0, 1));

    reset        = 1'b1;
    lookup_valid = 1'b0;
    lookup_pc    = '0;
    upd_valid    = 1'b0;
    upd_pc       = '0;
    upd_taken    = 1'b0;
    repeat (3) step();
    check("rst_q_count", 32'(q_count), 32'd0);
    check("rst_pred_valid", 32'(pred_valid), 32'd0);
    check("rst_pred_taken", 32'(pred_taken), 32'd0);
    check("rst_lookup_ready", 32'(lookup_ready), 32'd0);
    reset = 1'b0;
    count_init("init1");

    run_vec(vecs[0], 0);

    // Train: two back-to-back taken updates to 0x104, drained in two cycles.
    wait_idle("train");
    upd_valid = 1'b1;
    upd_pc    = 32'h104;
    upd_taken = 1'b1;
    step();
    check("train_q_after_push1", 32'(q_count), 32'd1);
    step();
    upd_valid = 1'b0;
    check("train_q_after_push2", 32'(q_count), 32'd1);
    step();
    check("train_q_drained", 32'(q_count), 32'd0);

    for (int k = 1; k < vecs.size(); k++) run_vec(vecs[k], k);

    // Contention: lookups every cycle, four updates fill the queue.
    wait_idle("cont");
    lookup_valid = 1'b1;
    lookup_pc    = 32'h0;
    upd_pc       = 32'h20;
    upd_taken    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont_upd_ready_%0d", i), 32'(upd_ready), 32'd1);
      upd_valid = 1'b1;
      step();
      check($sformatf("cont_q_count_%0d", i), 32'(q_count), 32'(i + 1));
      if (i == 0) check("cont_pred_taken", 32'(pred_taken), 32'd1);
    end
    upd_valid = 1'b0;
    check("cont_full_upd_ready", 32'(upd_ready), 32'd0);
    check("cont_full_lookup_ready", 32'(lookup_ready), 32'd0);
    step();
    check("cont_drain_q_count", 32'(q_count), 32'd3);
    check("cont_stall_pred_valid", 32'(pred_valid), 32'd0);
    check("cont_lookup_ready_again", 32'(lookup_ready), 32'd1);
    check("cont_upd_ready_again", 32'(upd_ready), 32'd1);

    // Reset mid-run with three updates still queued.
    lookup_valid = 1'b0;
    reset        = 1'b1;
    step();
    check("mid_rst_q_count", 32'(q_count), 32'd0);
    check("mid_rst_pred_valid", 32'(pred_valid), 32'd0);
    check("mid_rst_lookup_ready", 32'(lookup_ready), 32'd0);
    reset = 1'b0;
    count_init("init2");
    run_vec(mk(1, 32'h0,   0, 0), 100);
    run_vec(mk(1, 32'h104, 0, 0), 101);
    run_vec(mk(1, 32'h10,  0, 0), 102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
